// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse period meter.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TOUT    = 2'd2
    } meter_state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 32'd1 << 20;

endpackage

// File: rtl/pulse_period_meter_if.sv
// Control and result signals of the pulse period meter.
interface pulse_period_meter_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             pulse_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;

    modport master (
        output enable, pulse_in,
        input  period, high_time, valid, timeout
    );

    modport slave (
        input  enable, pulse_in,
        output period, high_time, valid, timeout
    );
endinterface

// File: rtl/edge_sync.sv
// Synchronizer for the asynchronous pulse input plus registered rising-edge detect.
// s is the synchronized level delayed by one flop so it lines up with rise:
// in the cycle rise is high, s is high too, and counting s from there gives
// exactly the high cycles of the period that rise opens.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;

    // synchronizer chain, aligned level and edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            s      <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            s      <= sync_q[SYNC_STAGES-1];
            rise   <= sync_q[SYNC_STAGES-1] & ~s;
        end
    end

endmodule

// File: rtl/pulse_period_meter.sv
// Pulse period meter: reports period and high time of a pulse train with a
// one-cycle valid strobe, and flags loss of signal with a timeout level.
//
// state   | meaning
// IDLE    | waiting for the first rise; no period measured yet
// MEASURE | counting between rises; each rise reports a period
// TOUT    | no rise for TIMEOUT clocks; next rise re-arms without reporting
//
// Optional: define PULSE_PERIOD_AVG_EN to report the average of 2**AVG_LOG2
// consecutive periods/high times instead of every period.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
`ifdef PULSE_PERIOD_AVG_EN
    ,
    parameter int          AVG_LOG2    = 3
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    pulse_period_meter_if.slave  bus
);

    localparam logic [CNT_W-1:0] TOUT_CNT = CNT_W'(TIMEOUT);

    meter_state_e     state_q, state_d;
    logic             s, rise;
    logic [CNT_W-1:0] cnt, hcnt;
    logic [CNT_W-1:0] period_q, high_q;
    logic             valid_q, timeout_q;
    logic             sample_en, tout_set, tout_clr, at_limit;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pulse_in),
        .s     (s),
        .rise  (rise)
    );

    assign at_limit = (cnt == TOUT_CNT);

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state logic; a rise on the limit cycle wins over the timeout
    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (rise) state_d = MEASURE;
                MEASURE: if (!rise && at_limit) state_d = TOUT;
                TOUT:    if (rise) state_d = MEASURE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM control strobes
    always_comb begin
        sample_en = 1'b0;
        tout_set  = 1'b0;
        tout_clr  = 1'b0;
        if (bus.enable) begin
            case (state_q)
                MEASURE: begin
                    sample_en = rise;
                    tout_set  = !rise && at_limit;
                end
                TOUT:    tout_clr = rise;
                default: ;
            endcase
        end
    end

    // period and high-time counters, restarted by every rise, saturating
    always_ff @(posedge clk) begin
        if (reset || !bus.enable) begin
            cnt  <= '0;
            hcnt <= '0;
        end else if (rise) begin
            cnt  <= CNT_W'(1);
            hcnt <= CNT_W'(1);
        end else begin
            if (cnt != '1)       cnt  <= cnt + 1'b1;
            if (s && hcnt != '1) hcnt <= hcnt + 1'b1;
        end
    end

    // timeout level: set on the limit, cleared by a rise or by disabling
    always_ff @(posedge clk) begin
        if (reset || !bus.enable) timeout_q <= 1'b0;
        else if (tout_set)        timeout_q <= 1'b1;
        else if (tout_clr)        timeout_q <= 1'b0;
    end

`ifdef PULSE_PERIOD_AVG_EN
    localparam int ACC_W = CNT_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_p, acc_h, sum_p, sum_h;
    logic [AVG_LOG2-1:0] blk;

    assign sum_p = acc_p + ACC_W'(cnt);
    assign sum_h = acc_h + ACC_W'(hcnt);

    // block accumulator; a partial block is dropped outside MEASURE or on timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            acc_p    <= '0;
            acc_h    <= '0;
            blk      <= '0;
        end else begin
            valid_q <= 1'b0;
            if (!bus.enable || state_q != MEASURE || tout_set) begin
                acc_p <= '0;
                acc_h <= '0;
                blk   <= '0;
            end else if (sample_en) begin
                if (blk == '1) begin
                    period_q <= CNT_W'(sum_p >> AVG_LOG2);
                    high_q   <= CNT_W'(sum_h >> AVG_LOG2);
                    valid_q  <= 1'b1;
                    acc_p    <= '0;
                    acc_h    <= '0;
                    blk      <= '0;
                end else begin
                    acc_p <= sum_p;
                    acc_h <= sum_h;
                    blk   <= blk + 1'b1;
                end
            end
        end
    end
`else
    // capture each completed period
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (sample_en) begin
                period_q <= cnt;
                high_q   <= hcnt;
                valid_q  <= 1'b1;
            end
        end
    end
`endif

    assign bus.period    = period_q;
    assign bus.high_time = high_q;
    assign bus.valid     = valid_q;
    assign bus.timeout   = timeout_q;

endmodule
